// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// The master side is the requester pair; the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int WORD = 64
);
  logic            req0_valid;
  logic            req0_ready;
  logic [WORD-1:0] req0_a;
  logic [WORD-1:0] req0_b;
  logic [3:0]      req0_ctl;

  logic            req1_valid;
  logic            req1_ready;
  logic [WORD-1:0] req1_a;
  logic [WORD-1:0] req1_b;
  logic [3:0]      req1_ctl;

  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [WORD-1:0] rsp0_result;
  logic            rsp0_zero;

  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [WORD-1:0] rsp1_result;
  logic            rsp1_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctl,
    output req1_valid, req1_a, req1_b, req1_ctl,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctl,
    input  req1_valid, req1_a, req1_b, req1_ctl,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE (accept) -> EXEC (capture) -> RESP
// (hand result back). Ties alternate against the previous grant.
module alu_arbiter #(
  parameter int WORD = 64,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    bus,
  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [WORD-1:0] alu_result,
  input  logic            alu_zero,
  output logic            busy,
  output logic [CNTW-1:0] done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic owner_q;
  logic last_grant_q;
  logic grant;
  logic accept;
  logic rsp_fire;

  logic [WORD-1:0] a_p0;
  logic [WORD-1:0] b_p0;
  logic [3:0]      ctl_p0;

  logic [WORD-1:0] res0_p1;
  logic [WORD-1:0] res1_p1;
  logic            zero0_p1;
  logic            zero1_p1;

  // Pick a requester: a lone valid wins, a tie goes to whoever was not served last.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // Next-state and handshake outputs; readies are gated by rst_n so every output is 0 in reset.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    rsp_fire       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        bus.rsp0_valid = ~owner_q;
        bus.rsp1_valid = owner_q;
        rsp_fire       = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, ownership, fairness pointer and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      done_count   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
      end
      if (rsp_fire) begin
        done_count <= done_count + 1'b1;
      end
    end
  end

  // Operand stage: latch the granted request onto the shared ALU and hold it until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      ctl_p0 <= '0;
    end else if (accept) begin
      a_p0   <= grant ? bus.req1_a   : bus.req0_a;
      b_p0   <= grant ? bus.req1_b   : bus.req0_b;
      ctl_p0 <= grant ? bus.req1_ctl : bus.req0_ctl;
    end
  end

  // Result stage: only the owner's register is written, so the other side keeps its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0_p1  <= '0;
      res1_p1  <= '0;
      zero0_p1 <= 1'b0;
      zero1_p1 <= 1'b0;
    end else if (state_q == EXEC) begin
      if (owner_q) begin
        res1_p1  <= alu_result;
        zero1_p1 <= alu_zero;
      end else begin
        res0_p1  <= alu_result;
        zero0_p1 <= alu_zero;
      end
    end
  end

  assign alu_a           = a_p0;
  assign alu_b           = b_p0;
  assign alu_control     = ctl_p0;
  assign bus.rsp0_result = res0_p1;
  assign bus.rsp0_zero   = zero0_p1;
  assign bus.rsp1_result = res1_p1;
  assign bus.rsp1_zero   = zero1_p1;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;
  localparam int WORD = 64;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WORD(WORD)) bus ();

  logic [WORD-1:0] alu_a, alu_b, alu_result;
  logic [3:0]      alu_control;
  logic            alu_zero, busy;
  logic [CNTW-1:0] done_count;

  alu_arbiter #(.WORD(WORD), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .done_count(done_count)
  );

  // Reference ALU, also used to drive the DUT's shared ALU port.
  function automatic logic [WORD-1:0] alu_ref(input logic [3:0] c, input logic [WORD-1:0] a,
                                             input logic [WORD-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? WORD'(1) : WORD'(0);
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_control, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkc(input string name, input logic [CNTW-1:0] act, input logic [CNTW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // An accepted operation produces its response two edges after acceptance,
  // keeps it until the owner takes it, and only then may a new grant happen.
  logic            m_inflight;
  int              m_age;
  logic            m_owner, m_last;
  logic [WORD-1:0] m_a, m_b, m_res;
  logic [3:0]      m_ctl;
  logic [WORD-1:0] m_shown [2];
  logic            m_zshown [2];
  int unsigned     m_done;

  always @(negedge clk) begin
    logic v0, v1, g, er0, er1, rv;
    if (!rst_n) begin
      checkb("rst_busy", busy, 1'b0);
      checkb("rst_req0_ready", bus.req0_ready, 1'b0);
      checkb("rst_req1_ready", bus.req1_ready, 1'b0);
      checkb("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
      checkb("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
      check("rst_alu_a", alu_a, '0);
      check("rst_rsp0_result", bus.rsp0_result, '0);
      check("rst_rsp1_result", bus.rsp1_result, '0);
      checkc("rst_done_count", done_count, '0);
      m_inflight = 1'b0; m_age = 0; m_owner = 1'b0; m_last = 1'b1;
      m_a = '0; m_b = '0; m_ctl = '0; m_res = '0;
      m_shown[0] = '0; m_shown[1] = '0; m_zshown[0] = 1'b0; m_zshown[1] = 1'b0;
      m_done = 0;
    end else begin
      v0  = bus.req0_valid;
      v1  = bus.req1_valid;
      g   = (v0 && v1) ? ~m_last : v1;
      er0 = !m_inflight && v0 && !g;
      er1 = !m_inflight && v1 && g;
      rv  = m_inflight && (m_age >= 2);
      checkb("m_busy", busy, m_inflight);
      checkb("m_req0_ready", bus.req0_ready, er0);
      checkb("m_req1_ready", bus.req1_ready, er1);
      checkb("m_rsp0_valid", bus.rsp0_valid, rv && !m_owner);
      checkb("m_rsp1_valid", bus.rsp1_valid, rv && m_owner);
      check("m_rsp0_result", bus.rsp0_result, m_shown[0]);
      check("m_rsp1_result", bus.rsp1_result, m_shown[1]);
      checkb("m_rsp0_zero", bus.rsp0_zero, m_zshown[0]);
      checkb("m_rsp1_zero", bus.rsp1_zero, m_zshown[1]);
      check("m_alu_a", alu_a, m_a);
      check("m_alu_b", alu_b, m_b);
      check("m_alu_control", WORD'(alu_control), WORD'(m_ctl));
      checkc("m_done_count", done_count, CNTW'(m_done));
      // advance the model across the coming rising edge
      if (m_inflight) begin
        if (m_age >= 2) begin
          if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
            m_inflight = 1'b0;
            m_done++;
          end
        end else begin
          m_age++;
          if (m_age == 2) begin
            m_shown[m_owner]  = m_res;
            m_zshown[m_owner] = (m_res == '0);
          end
        end
      end else if (er0 || er1) begin
        m_inflight = 1'b1;
        m_age      = 1;
        m_owner    = g;
        m_last     = g;
        m_a        = g ? bus.req1_a   : bus.req0_a;
        m_b        = g ? bus.req1_b   : bus.req0_b;
        m_ctl      = g ? bus.req1_ctl : bus.req0_ctl;
        m_res      = alu_ref(m_ctl, m_a, m_b);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctl = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctl = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] rand_ctl();
    case ($urandom_range(0, 6))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0111;
      5: return 4'b1100;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int order [4];
    logic acc0, acc1;

    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester ADD 15+10.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 64'd15; bus.req0_b = 64'd10; bus.req0_ctl = 4'b0010;
    bus.rsp0_ready = 1'b1;
    #1;
    checkb("add_req0_ready", bus.req0_ready, 1'b1);
    checkb("add_req1_ready", bus.req1_ready, 1'b0);
    cyc();
    bus.req0_valid = 1'b0;
    #1;
    checkb("add_exec_rsp0_valid", bus.rsp0_valid, 1'b0);
    checkb("add_exec_busy", busy, 1'b1);
    cyc();
    #1;
    checkb("add_rsp0_valid", bus.rsp0_valid, 1'b1);
    check("add_rsp0_result", bus.rsp0_result, 64'd25);
    checkb("add_rsp0_zero", bus.rsp0_zero, 1'b0);
    cyc();
    #1;
    checkc("add_done_count", done_count, 4'd1);
    checkb("add_idle_busy", busy, 1'b0);

    // Tie after reset: req0 SUB first, then req1 ORR.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 64'd15; bus.req0_b = 64'd15; bus.req0_ctl = 4'b0110;
    bus.req1_valid = 1'b1; bus.req1_a = 64'd15; bus.req1_b = 64'd10; bus.req1_ctl = 4'b0001;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    checkb("tie_req0_ready", bus.req0_ready, 1'b1);
    checkb("tie_req1_ready", bus.req1_ready, 1'b0);
    cyc();
    bus.req0_valid = 1'b0;
    cyc();
    #1;
    checkb("tie_rsp0_valid", bus.rsp0_valid, 1'b1);
    check("tie_rsp0_result", bus.rsp0_result, 64'd0);
    checkb("tie_rsp0_zero", bus.rsp0_zero, 1'b1);
    checkb("tie_req1_wait", bus.req1_ready, 1'b0);
    cyc();
    #1;
    checkb("tie_req1_ready", bus.req1_ready, 1'b1);
    cyc();
    bus.req1_valid = 1'b0;
    cyc();
    #1;
    checkb("tie_rsp1_valid", bus.rsp1_valid, 1'b1);
    check("tie_rsp1_result", bus.rsp1_result, 64'd15);
    checkb("tie_rsp1_zero", bus.rsp1_zero, 1'b0);
    check("tie_rsp0_retained", bus.rsp0_result, 64'd0);
    cyc();
    #1;
    checkc("tie_done_count", done_count, 4'd2);

    // Both held valid: grants alternate 0,1,0,1.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 64'd5; bus.req0_b = 64'd3; bus.req0_ctl = 4'b0010;
    bus.req1_valid = 1'b1; bus.req1_a = 64'd9; bus.req1_b = 64'd4; bus.req1_ctl = 4'b0110;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      #1;
      if (bus.req0_ready) begin order[n] = 0; n++; end
      else if (bus.req1_ready) begin order[n] = 1; n++; end
      cyc();
    end
    checki("alt_grant_count", n, 4);
    checki("alt_grant0", order[0], 0);
    checki("alt_grant1", order[1], 1);
    checki("alt_grant2", order[2], 0);
    checki("alt_grant3", order[3], 1);

    // Back-pressure on rsp1 with req0 pending.
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_a = 64'd100; bus.req1_b = 64'd58; bus.req1_ctl = 4'b0110;
    #1;
    checkb("bp_req1_ready", bus.req1_ready, 1'b1);
    cyc();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 64'd7; bus.req0_b = 64'd7; bus.req0_ctl = 4'b0000;
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      checkb("bp_rsp1_valid", bus.rsp1_valid, 1'b1);
      check("bp_rsp1_result", bus.rsp1_result, 64'd42);
      checkb("bp_req0_ready", bus.req0_ready, 1'b0);
      checkb("bp_busy", busy, 1'b1);
      cyc();
    end
    bus.rsp1_ready = 1'b1;
    bus.rsp0_ready = 1'b1;
    cyc();
    #1;
    checkb("bp_rsp1_done", bus.rsp1_valid, 1'b0);
    checkc("bp_done_count", done_count, 4'd1);
    checkb("bp_req0_served", bus.req0_ready, 1'b1);
    cyc();
    bus.req0_valid = 1'b0;
    cyc();
    #1;
    checkb("bp_rsp0_valid", bus.rsp0_valid, 1'b1);
    check("bp_rsp0_result", bus.rsp0_result, 64'd7);
    check("bp_rsp1_retained", bus.rsp1_result, 64'd42);

    // Reset pulse while an operation is in EXEC.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 64'd1; bus.req0_b = 64'd2; bus.req0_ctl = 4'b0010;
    bus.rsp0_ready = 1'b1;
    repeat (4) cyc();
    #1;
    checkb("rx_busy_before", busy, 1'b1);
    checkc("rx_done_before", done_count, 4'd1);
    rst_n = 1'b0;
    #1;
    checkb("rx_busy", busy, 1'b0);
    checkb("rx_req0_ready", bus.req0_ready, 1'b0);
    check("rx_alu_a", alu_a, '0);
    check("rx_alu_control", WORD'(alu_control), '0);
    check("rx_rsp0_result", bus.rsp0_result, '0);
    checkc("rx_done_count", done_count, 4'd0);
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checkb("rx_no_rsp0", bus.rsp0_valid, 1'b0);
      checkb("rx_no_rsp1", bus.rsp1_valid, 1'b0);
    end
    checkc("rx_done_after", done_count, 4'd0);

    // 17 back-to-back operations wrap a 4-bit counter to 1.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 64'd3; bus.req0_b = 64'd4; bus.req0_ctl = 4'b0010;
    bus.rsp0_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.rsp0_valid) n++;
      if (n == 17) break;
      cyc();
    end
    checki("wrap_ops", n, 17);
    bus.req0_valid = 1'b0;
    cyc();
    #1;
    checkc("wrap_done_count", done_count, 4'd1);

    // Randomized traffic; operands stay put until accepted.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (i == 1500) begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        continue;
      end
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_a     = {$urandom, $urandom};
        bus.req0_b     = ($urandom_range(0, 3) == 0) ? bus.req0_a : {$urandom, $urandom};
        bus.req0_ctl   = rand_ctl();
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_a     = {$urandom, $urandom};
        bus.req1_b     = ($urandom_range(0, 3) == 0) ? bus.req1_a : {$urandom, $urandom};
        bus.req1_ctl   = rand_ctl();
      end
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WORD, default 64, datapath width of operands and result.
REQ-002 Parameter CNTW, default 16, width of completion counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 presents an operation.
REQ-006 req0_ready  output  1  arbiter accepts requester 0 operation this cycle.
REQ-007 req0_a, req0_b  input  WORD each  requester 0 operands.
REQ-008 req0_ctl  input  4  requester 0 ALU control code.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_ctl  same directions/widths as REQ-005..008, requester 1.
REQ-010 rsp0_valid  output  1  result for requester 0 available.
REQ-011 rsp0_ready  input  1  requester 0 consumes result.
REQ-012 rsp0_result  output  WORD; rsp0_zero  output  1  captured ALU result and zero flag.
REQ-013 rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero  same as REQ-010..012, requester 1.
REQ-014 alu_a, alu_b  output  WORD each; alu_control  output  4  drive shared ALU.
REQ-015 alu_result  input  WORD; alu_zero  input  1  from shared combinational ALU.
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 done_count  output  CNTW  number of completed responses.

Function
REQ-018 FSM SHALL have states IDLE, EXEC, RESP.
REQ-019 IDLE: reqN_ready SHALL be high combinationally only for the granted requester, only while its reqN_valid is high; other ready low.
REQ-020 Grant: only one valid -> that one; both valid -> requester not equal to last_grant; neither valid -> stay IDLE.
REQ-021 On acceptance edge, arbiter SHALL register a, b, ctl onto alu_a/alu_b/alu_control, record owner, set last_grant = owner, go EXEC.
REQ-022 EXEC (one cycle): SHALL capture alu_result/alu_zero into owner's result register, go RESP.
REQ-023 RESP: rspN_valid high for owner only; rspN_result/rspN_zero stable until handshake.
REQ-024 Handshake rspN_valid && rspN_ready at edge SHALL increment done_count (wraps modulo 2^CNTW) and return to IDLE.
REQ-025 rsp_ready asserted before or on the cycle rsp_valid rises SHALL complete in that cycle; ready of non-owner SHALL be ignored.
REQ-026 Latency: accept at edge t -> rsp_valid high from t+2; minimum 3 cycles per operation.
REQ-027 alu_a/alu_b/alu_control SHALL hold last registered values in EXEC, RESP and IDLE.
REQ-028 No req ready asserted outside IDLE; requests held pending are not dropped.
REQ-029 Requesters must hold valid and operands stable until ready; arbiter does not check this.
REQ-030 rsp_result/rsp_zero of a non-owner SHALL retain their last captured values.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, last_grant = 1 (so req0 wins first tie), all outputs 0, done_count 0.
REQ-032 Reset during EXEC or RESP SHALL abandon the operation; no response issued after release.
REQ-033 First acceptance possible on the first rising edge with rst_n high.

Verification
REQ-034 req0 only, a=15, b=10, ctl=0010 (ADD) -> req0_ready in IDLE, rsp0_valid 2 cycles later, rsp0_result=25, rsp0_zero=0, done_count=1.
REQ-035 req0 and req1 valid together after reset (req0 SUB 15-15, req1 ORR 15|10) -> req0 served first: result 0, zero=1; req1 next: result 15; done_count=2.
REQ-036 Both held valid for 4 operations -> grants alternate 0,1,0,1; no requester served twice consecutively.
REQ-037 rsp1_ready held low 5 cycles in RESP -> rsp1_valid and result stable, req0_ready stays 0, busy=1; completes on ready.
REQ-038 rst_n pulsed low during EXEC -> all outputs 0 asynchronously, no rsp_valid after release, done_count=0.
REQ-039 CNTW=4, 17 back-to-back operations -> done_count wraps to 1.
